multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants in mips_pkg.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register; stable from DECODE to end of instruction.
REQ-005 mem_ready  in  1  memory handshake; the access completes in a cycle where mem_ready=1.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDest  out  1 each  datapath strobes/selects.
REQ-007 ALUOp  out  2  00 add, 01 subtract (beq), 10 funct-decoded.
REQ-008 ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-009 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-011 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-012 state  out  4  current state code, for debug.

Function
REQ-013 Moore FSM, 12 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-014 Opcode decode: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
REQ-015 Transitions out of FETCH and DECODE:
- FETCH->DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE->MEMADR for lw/sw, EXEC for R, BRANCH for beq, JUMP for j, ADDIEX for addi.
- Any other opcode in DECODE: go to FETCH and assert illegal_op.
REQ-016 Remaining transitions:
- MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
- MEMRD->MEMWB only when mem_ready=1; otherwise hold.
- MEMWR->FETCH only when mem_ready=1; otherwise hold.
- EXEC->RWB; ADDIEX->ADDIWB.
- MEMWB, RWB, BRANCH, JUMP, ADDIWB -> FETCH.
REQ-017 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready (Mealy-qualified).
REQ-018 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-019 MEMADR and ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-020 Memory-state outputs:
- MEMRD: MemRead=1, IorD=1.
- MEMWR: MemWrite=1, IorD=1.
REQ-021 Writeback outputs: RegWrite=1, plus
- MEMWB: RegDest=0, MemtoReg=1.
- RWB: RegDest=1, MemtoReg=0.
- ADDIWB: RegDest=0, MemtoReg=0.
REQ-022 EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-023 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-024 JUMP outputs: PCWrite=1, PCSource=10.
REQ-025 Every output not listed for a state SHALL be 0.
REQ-026 instr_done SHALL be 1 in:
- MEMWB, RWB, BRANCH, JUMP, ADDIWB;
- MEMWR when mem_ready=1.
REQ-027 Latency with mem_ready held at 1: lw 5 cycles, sw/R/addi 4, beq/j 3.
REQ-028 Each extra mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle; no strobe may repeat.
REQ-029 A 1-cycle mem_ready glitch while outside a memory state SHALL have no effect.

Reset
REQ-030 While rst=1, every output SHALL be 0, including MemRead and the state code.
REQ-031 On the first edge after rst falls, the FSM SHALL be in FETCH.
REQ-032 rst asserted mid-instruction SHALL abandon it: no RegWrite/MemWrite/PCWrite in the reset cycle; restart in FETCH.
REQ-033 rst takes priority over mem_ready and opcode.

Structure
REQ-034 mips_pkg SHALL hold:
- the state enum (4-bit);
- the opcode constants;
- the ALUOp, ALUSrcB and PCSource encodings.
REQ-035 Implementation is a single module: state register plus next-state and output logic; no sub-module.

Verification
REQ-036 lw (100011), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in state 4; instr_done once.
REQ-037 sw (101011), mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles; exactly one instr_done; then FETCH.
REQ-038 beq (000100) -> states 0,1,8; PCWriteCond=1, PCSource=01, ALUOp=01 in state 8.
REQ-039 opcode 111111 -> states 0,1,0; illegal_op=1 for one cycle; RegWrite/MemWrite never asserted.
REQ-040 Mid-flow reset: R-type (000000) with rst=1 during EXEC -> all outputs 0 in the reset cycle; state 0 afterwards; RWB never reached.
REQ-041 Fetch stall: mem_ready=0 for 2 cycles in FETCH -> IRWrite and PCWrite each pulse exactly once, on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the datapath mux/ALU select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS: sequences fetch, decode and the
// per-opcode execute/memory/writeback steps, waiting on mem_ready for memory.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDest,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Only the three memory states wait on mem_ready; all others advance unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = RWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low during reset so an abandoned instruction cannot write anything.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDest     = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REGB;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    state       = 4'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = SRCB_IMMSH;
          illegal_op = !is_legal(opcode);
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        RWB: begin
          RegWrite   = 1'b1;
          RegDest    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level latency table, hand-written
// corner sequences, and random traffic checked every cycle against a step-list model.
module tb_multicycle_control;

  typedef struct packed {
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDest;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic       illegal_op, instr_done;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic [5:0] op;
    int         lat;
    logic       ends_illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDest;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  int   m_state = 0;
  int   plan[$];
  out_t act, s;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDest(RegDest), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDest, ALUOp, ALUSrcB,
                PCSource, illegal_op, instr_done, state};

  always #5 clk = ~clk;

  // Each opcode expands to the list of steps it walks after DECODE.
  function automatic void load_path(input logic [5:0] op);
    plan.delete();
    case (op)
      6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2); plan.push_back(5); end
      6'b000000: begin plan.push_back(6); plan.push_back(7); end
      6'b001000: begin plan.push_back(10); plan.push_back(11); end
      6'b000100: plan.push_back(8);
      6'b000010: plan.push_back(9);
      default:   plan.push_back(0);
    endcase
  endfunction

  function automatic out_t exp_out(input int st, input logic mr, input logic [5:0] op);
    out_t o;
    o = '0;
    o.state = st[3:0];
    case (st)
      0:  begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.PCWrite = mr; end
      1:  begin
            o.ALUSrcB = 2'b11;
            o.illegal_op = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                             op == 6'b000100 || op == 6'b000010 || op == 6'b001000);
          end
      2, 10: begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      3:  begin o.MemRead = 1; o.IorD = 1; end
      4:  begin o.RegWrite = 1; o.MemtoReg = 1; o.instr_done = 1; end
      5:  begin o.MemWrite = 1; o.IorD = 1; o.instr_done = mr; end
      6:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
      7:  begin o.RegWrite = 1; o.RegDest = 1; o.instr_done = 1; end
      8:  begin
            o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1;
            o.PCSource = 2'b01; o.instr_done = 1;
          end
      9:  begin o.PCWrite = 1; o.PCSource = 2'b10; o.instr_done = 1; end
      11: begin o.RegWrite = 1; o.instr_done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Reference step tracker: memory steps (0, 3, 5) hold until mem_ready.
  always @(posedge clk) begin : model
    int nxt;
    nxt = m_state;
    if (rst) begin
      nxt = 0;
      plan.delete();
    end else if (m_state == 0) begin
      if (mem_ready) nxt = 1;
    end else if (m_state == 1) begin
      load_path(opcode);
      nxt = plan.pop_front();
    end else if (!((m_state == 3 || m_state == 5) && !mem_ready)) begin
      nxt = (plan.size() > 0) ? plan.pop_front() : 0;
    end
    m_state <= nxt;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : scoreboard
    out_t e;
    if (chk_en) begin
      if (rst) e = '0;
      else     e = exp_out(m_state, mem_ready, opcode);
      checkOutput("cycle_outputs", 32'(act), 32'(e));
    end
  end

  // Drive one cycle of inputs and capture the outputs mid-cycle.
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
    rst = r;
    opcode = op;
    mem_ready = mr;
    @(negedge clk);
    s = act;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[7];
    int   lat, cnt_a, cnt_b, cnt_c;
    logic ended_ill;
    int   lw_tr[5]  = '{0, 1, 2, 3, 4};
    logic sw_mr[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int   beq_tr[3] = '{0, 1, 8};
    int   ill_tr[3] = '{0, 1, 0};
    logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000010, 6'b001000, 6'b111111};
    logic [5:0] cur_op;

    vecs[0] = '{6'b100011, 5, 1'b0};
    vecs[1] = '{6'b101011, 4, 1'b0};
    vecs[2] = '{6'b000000, 4, 1'b0};
    vecs[3] = '{6'b001000, 4, 1'b0};
    vecs[4] = '{6'b000100, 3, 1'b0};
    vecs[5] = '{6'b000010, 3, 1'b0};
    vecs[6] = '{6'b111111, 2, 1'b1};

    chk_en = 1'b1;
    applyStimulus(1'b1, 6'b100011, 1'b0);
    applyStimulus(1'b1, 6'b100011, 1'b1);
    checkOutput("reset_outputs", 32'(s), 32'd0);

    for (int i = 0; i < 7; i++) begin
      lat = 0;
      ended_ill = 1'b0;
      for (int c = 0; c < 12; c++) begin
        applyStimulus(1'b0, vecs[i].op, 1'b1);
        lat++;
        if (s.instr_done || s.illegal_op) begin
          ended_ill = s.illegal_op;
          break;
        end
      end
      checkOutput($sformatf("latency_op%b", vecs[i].op), lat, vecs[i].lat);
      checkOutput($sformatf("end_kind_op%b", vecs[i].op), 32'(ended_ill), 32'(vecs[i].ends_illegal));
    end

    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 6'b100011, 1'b1);
      checkOutput("lw_state", 32'(s.state), lw_tr[i]);
      cnt_a += int'(s.instr_done);
    end
    checkOutput("lw_writeback", {30'd0, s.RegWrite, s.MemtoReg}, 32'd3);
    checkOutput("lw_done_count", cnt_a, 1);

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 6'b101011, sw_mr[i]);
      cnt_a += int'(s.MemWrite);
      cnt_b += int'(s.instr_done);
    end
    checkOutput("sw_memwrite_cycles", cnt_a, 4);
    checkOutput("sw_done_count", cnt_b, 1);
    applyStimulus(1'b0, 6'b000010, 1'b0);
    checkOutput("sw_back_to_fetch", 32'(s.state), 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b000100, 1'b1);
      checkOutput("beq_state", 32'(s.state), beq_tr[i]);
    end
    checkOutput("beq_controls", {27'd0, s.PCWriteCond, s.PCSource, s.ALUOp}, 32'b10101);

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b111111, (i < 2) ? 1'b1 : 1'b0);
      checkOutput("illegal_state", 32'(s.state), ill_tr[i]);
      cnt_a += int'(s.illegal_op);
      cnt_b += int'(s.RegWrite) + int'(s.MemWrite);
    end
    checkOutput("illegal_pulse_count", cnt_a, 1);
    checkOutput("illegal_no_writes", cnt_b, 0);

    cnt_a = 0;
    applyStimulus(1'b0, 6'b000000, 1'b1);
    applyStimulus(1'b0, 6'b000000, 1'b1);
    applyStimulus(1'b1, 6'b000000, 1'b1);
    checkOutput("midreset_outputs", 32'(s), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 6'b000010, (i == 0) ? 1'b0 : 1'b1);
      if (i == 0) checkOutput("midreset_fetch", 32'(s.state), 32'd0);
      cnt_a += int'(s.state == 4'd7);
    end
    checkOutput("midreset_no_rwb", cnt_a, 0);

    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'b001000, (i == 2) ? 1'b1 : 1'b0);
      cnt_a += int'(s.IRWrite);
      cnt_b += int'(s.PCWrite);
    end
    checkOutput("stall_irwrite_last", {30'd0, s.IRWrite, s.PCWrite}, 32'd3);
    checkOutput("stall_irwrite_count", cnt_a, 1);
    checkOutput("stall_pcwrite_count", cnt_b, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'b001000, 1'b1);

    // Random traffic; the opcode may only change while the model is in FETCH.
    cur_op = 6'b000000;
    for (int i = 0; i < 600; i++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
        else                           cur_op = ops[$urandom_range(0, 6)];
      end
      applyStimulus(($urandom_range(0, 39) == 0), cur_op, ($urandom_range(0, 3) != 0));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
